lenet_fmap_tx: RTL

Frame transmitter for the LeNet pipeline. It buffers one feature map (ROWS×COLS pixels, WD bits each) through a random-access write port. On command it streams the map out on the vsync/hsync/valid/tdata pixel interface that the convolution layers consume. It sits in front of a conv layer so a stored map (for example, the pooled S2 output) can be replayed to it frame by frame with fixed, programmable blanking.

---
 rtl/lenet_fmap_tx.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/lenet_fmap_tx.sv
// lenet_fmap_tx - feature-map frame transmitter.
//
// Holds one ROWS x COLS map of WD-bit pixels, loaded through a random-access
// write port while idle. A start request replays the map in raster order on
// a vsync/hsync/valid/tdata pixel stream with fixed blanking:
//   vsync, VGAP idle, then per row: hsync, HGAP idle, COLS pixels, LGAP idle,
//   and finally a one-cycle done pulse.
//
// Optional build macro: LENET_FMAP_TX_LOOP_EN - a start request seen while in
// DONE chains the next frame straight away (busy stays high).
//
// Ports:
//   i_sclk     clock, rising edge
//   i_rstn     asynchronous active-low reset
//   i_wr_en    buffer write strobe (ignored while busy or out of range)
//   i_wr_addr  raster address row*COLS+col
//   i_wr_data  pixel to store
//   i_start    one-cycle frame request (honoured only when idle)
//   o_busy     frame in progress
//   o_done     one-cycle end-of-frame pulse
//   o_vsync    frame-start pulse
//   o_hsync    row-start pulse
//   o_valid    pixel qualifier
//   o_tdata    pixel data, zero outside valid cycles
module lenet_fmap_tx #(
  parameter int WD   = 3,
  parameter int ROWS = 14,
  parameter int COLS = 14,
  parameter int VGAP = 4,
  parameter int HGAP = 4,
  parameter int LGAP = 8
) (
  input  logic                          i_sclk,
  input  logic                          i_rstn,
  input  logic                          i_wr_en,
  input  logic [$clog2(ROWS*COLS)-1:0]  i_wr_addr,
  input  logic [WD-1:0]                 i_wr_data,
  input  logic                          i_start,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_vsync,
  output logic                          o_hsync,
  output logic                          o_valid,
  output logic [WD-1:0]                 o_tdata
);

  localparam int NPIX = ROWS * COLS;
  localparam int AW   = $clog2(NPIX);
  localparam int GMAX = (VGAP > HGAP) ? ((VGAP > LGAP) ? VGAP : LGAP)
                                      : ((HGAP > LGAP) ? HGAP : LGAP);
  localparam int GW   = (GMAX > 1) ? $clog2(GMAX + 1) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS + 1) : 1;

  localparam logic [GW-1:0] VG_LAST  = GW'((VGAP > 0) ? VGAP - 1 : 0);
  localparam logic [GW-1:0] HG_LAST  = GW'((HGAP > 0) ? HGAP - 1 : 0);
  localparam logic [GW-1:0] LG_LAST  = GW'((LGAP > 0) ? LGAP - 1 : 0);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [AW:0]   NPIX_X   = (AW + 1)'(NPIX);

  typedef enum logic [2:0] {
    IDLE, VSYNC, VBLANK, HSYNC, HBLANK, LINE, LBLANK, DONE
  } state_t;

  state_t          state, state_d;
  logic            start_req;
  logic [GW-1:0]   gap_cnt;
  logic [CW-1:0]   col_cnt;
  logic [RW-1:0]   row_cnt;
  logic [AW-1:0]   rd_addr;
  logic [WD-1:0]   mem [NPIX];
  logic            wr_ok;

  logic            busy_d, done_d, vsync_d, hsync_d, valid_d;
  logic [WD-1:0]   tdata_d;

  // Pixel buffer: write port only while idle, no reset on the contents.
  assign wr_ok = i_wr_en && !o_busy && ({1'b0, i_wr_addr} < NPIX_X);

  always_ff @(posedge i_sclk) begin
    if (wr_ok) mem[i_wr_addr] <= i_wr_data;
  end

  // The start request is registered first, so o_vsync lands one cycle after
  // the sampling edge while outputs decode the same next-state as the FSM.
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= IDLE;
      start_req <= 1'b0;
    end else begin
      state     <= state_d;
      start_req <= (state == IDLE) && i_start && !start_req;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start_req) state_d = VSYNC;
      VSYNC:   state_d = (VGAP == 0) ? HSYNC : VBLANK;
      VBLANK:  if (gap_cnt == VG_LAST) state_d = HSYNC;
      HSYNC:   state_d = (HGAP == 0) ? LINE : HBLANK;
      HBLANK:  if (gap_cnt == HG_LAST) state_d = LINE;
      LINE:    if (col_cnt == COL_LAST) state_d = LBLANK;
      LBLANK:  if (gap_cnt == LG_LAST) state_d = (row_cnt == ROW_LAST) ? DONE : HSYNC;
`ifdef LENET_FMAP_TX_LOOP_EN
      DONE:    state_d = i_start ? VSYNC : IDLE;
`else
      DONE:    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the upcoming state; the read address is presented with it,
  // so the registered pixel lines up with o_valid.
  always_comb begin
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    vsync_d = (state_d == VSYNC);
    hsync_d = (state_d == HSYNC);
    valid_d = (state_d == LINE);
    tdata_d = '0;
    if (state_d == LINE) tdata_d = mem[rd_addr];
  end

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_vsync <= 1'b0;
      o_hsync <= 1'b0;
      o_valid <= 1'b0;
      o_tdata <= '0;
    end else begin
      o_busy  <= busy_d;
      o_done  <= done_d;
      o_vsync <= vsync_d;
      o_hsync <= hsync_d;
      o_valid <= valid_d;
      o_tdata <= tdata_d;
    end
  end

  // Gap/column counters restart on every state change; rows advance when a
  // line's trailing blank ends; the read pointer walks the whole raster.
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      gap_cnt <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
      rd_addr <= '0;
    end else begin
      if ((state_d == state) &&
          (state == VBLANK || state == HBLANK || state == LBLANK))
        gap_cnt <= gap_cnt + 1'b1;
      else
        gap_cnt <= '0;

      if (state == LINE && state_d == LINE) col_cnt <= col_cnt + 1'b1;
      else                                  col_cnt <= '0;

      if (state_d == VSYNC)                          row_cnt <= '0;
      else if (state == LBLANK && state_d != LBLANK) row_cnt <= row_cnt + 1'b1;

      if (state_d == VSYNC)     rd_addr <= '0;
      else if (state_d == LINE) rd_addr <= rd_addr + 1'b1;
    end
  end

endmodule
